swa_weight_ctrl: RTL and testbench
==================================

Name: swa_weight_ctrl

Overview:
- Per-input-port and per-input-VC weight counter bank for the combined VC/switch allocator.
- Produces `iport_weight_is_consumed_all` and `vc_weight_is_consumed_all` from switch-grant history and a run-time per-port weight.
- Lets the allocator's arbiters hold priority on a port or VC for WEIGHT consecutive grants before rotating.
- Sits between the router's input-port array and the allocator, in the same clock domain.

Parameters:
- P, 5, number of router ports.
- V, 4, virtual channels per port.
- WEIGHTw, 4, width of one weight value and of each counter.
- VC_WEIGHT, 2, fixed consecutive-grant quota per VC (1..2^WEIGHTw-1).

Ports:
- clk  input  1  router clock.
- reset  input  1  synchronous, active-high reset.
- iport_weight_all  input  P*WEIGHTw  requested weight per input port; port i uses bits [i*WEIGHTw +: WEIGHTw].
- ivc_request_all  input  P*V  per-IVC switch request, same bit order as the allocator (port-major, i = port*V + vc).
- ivc_num_getting_sw_grant  input  P*V  one-hot-per-port switch grant this cycle.
- any_ivc_sw_request_granted_all  input  P  OR of the grants per port.
- iport_weight_is_consumed_all  output  P  the next grant to this port exhausts its quota.
- vc_weight_is_consumed_all  output  P*V  the next grant to this VC exhausts its quota.
- weight_active_all  output  P*WEIGHTw  weight currently applied per port (shadow register).

Behaviour:
- **Clock and reset.** Single clock `clk`; reset is synchronous and active-high (`reset`).
- **Reset values.** On reset, all counters = 0, all outputs = 0, and `weight_active` = 1 per port.
- **Effective weight.** Ew = max(weight_active, 1). A weight value of 0 is treated as 1.
- **Port counter `pcnt[p]`:**
  - On `any_ivc_sw_request_granted_all[p]`: if pcnt == Ew-1, then pcnt <= 0; else pcnt <= pcnt+1.
  - Otherwise pcnt holds.
- **Port output.** `iport_weight_is_consumed_all[p] = (pcnt[p] == Ew[p]-1)`. It is decoded from registers only, with no combinational path from the inputs. With Ew = 1 it is constantly 1.
- **Shadow weight load.** `weight_active[p] <= iport_weight[p]` only in a cycle where pcnt[p] is 0 after update, i.e. pcnt wraps or stays at 0. A weight change therefore never splits a quota. Load takes effect the cycle after.
- **VC counter `vcnt[p][v]`** uses the same wrap rule with quota VC_WEIGHT, and increments on `ivc_num_getting_sw_grant[p*V+v]`.
- **VC counter clears:**
  - vcnt[p][v] clears to 0 when another VC of port p is granted.
  - vcnt[p][v] clears to 0 when `ivc_request_all[p*V+v]` is low, i.e. the packet finished or stalled.
  - Grant has priority over clear for the granted VC.
- **VC output.** `vc_weight_is_consumed_all[p*V+v] = (vcnt == VC_WEIGHT-1)`.
- **Grant input checks.** More than one grant bit set within a port is illegal. A simulation-only assertion flags it; RTL behaviour is then undefined.
- **Saturation.** Counters never exceed Ew-1. If weight_active drops below pcnt, the output is 0 until wrap. This is impossible by construction because load occurs only at pcnt = 0.
- **Reset mid-quota** discards all counts and restores weight_active to 1.
- **Latency.** Grant in cycle N is reflected in the outputs in cycle N+1.

Optional Feature:
- Macro: `SWA_WEIGHT_IDLE_RESET_EN`.
- **Defined:** a per-port idle counter of WEIGHTw bits counts cycles with no `ivc_request_all` bits set for port p.
  - On reaching 2^WEIGHTw-1, pcnt[p] clears to 0 and the weight shadow reloads.
  - Any request clears the idle counter.
  - Returning traffic then gets a full quota.
- **Undefined:** no idle counter; pcnt holds indefinitely while the port is idle.

Test Plan:
- **Reset value.** Reset, then `iport_weight[0]` = 3 with port-0 grants on 3 consecutive cycles. Expected:
  - `iport_weight_is_consumed_all[0]` = 1 from the cycle after reset (Ew = 1), with `weight_active[0]` loaded to 3 on cycle 1.
  - Then the output reads 0, 0, 1 over the following grants, and pcnt wraps to 0 after the third.
- **Weight 0.** Weight 0 on port 2 with grants every cycle → `iport_weight_is_consumed_all[2]` stays 1; pcnt[2] stays 0.
- **Weight change mid-quota.** Weight 4, 2 grants, then change to 2 → `weight_active` stays 4 until pcnt wraps after 2 more grants, then reads 2; consumed asserts after 1 further grant.
- **VC switch.** V = 4, VC_WEIGHT = 2, grant VC1, then VC1 → `vc_weight_is_consumed_all[1]` = 1 after the first grant. Grant VC2 → vcnt[1] clears and bit 1 = 0. Drop `ivc_request[2]` → vcnt[2] clears.
- **Reset mid-operation.** pcnt = 2, weight 5, assert reset for 1 cycle → all outputs 0 and weight_active = 1 the next cycle; the next grant with weight 5 starts the count from 0.
- **Idle reset (`SWA_WEIGHT_IDLE_RESET_EN`, WEIGHTw = 4).**
  - Setup: pcnt[0] = 2, weight 5, no requests for 15 cycles.
  - Defined: pcnt[0] = 0 on cycle 16.
  - Undefined: pcnt[0] remains 2.

Source files
------------

// File: rtl/swa_weight_ctrl.sv
// Weight counter bank for the combined VC/switch allocator: per-port and per-VC grant quotas.
// Optional idle-driven quota reset is enabled with `define SWA_WEIGHT_IDLE_RESET_EN.
module swa_weight_ctrl #(
  parameter int P         = 5,
  parameter int V         = 4,
  parameter int WEIGHTw   = 4,
  parameter int VC_WEIGHT = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [P*WEIGHTw-1:0] iport_weight_all,
  input  logic [P*V-1:0]       ivc_request_all,
  input  logic [P*V-1:0]       ivc_num_getting_sw_grant,
  input  logic [P-1:0]         any_ivc_sw_request_granted_all,
  output logic [P-1:0]         iport_weight_is_consumed_all,
  output logic [P*V-1:0]       vc_weight_is_consumed_all,
  output logic [P*WEIGHTw-1:0] weight_active_all
);

  localparam logic [WEIGHTw-1:0] CNT_ZERO = WEIGHTw'(0);
  localparam logic [WEIGHTw-1:0] CNT_ONE  = WEIGHTw'(1);
  localparam logic [WEIGHTw-1:0] VC_LAST  = WEIGHTw'(VC_WEIGHT - 1);

  // Last counter value of a quota; a weight of 0 behaves like 1.
  function automatic logic [WEIGHTw-1:0] quota_last(input logic [WEIGHTw-1:0] w);
    return (w == CNT_ZERO) ? CNT_ZERO : (w - CNT_ONE);
  endfunction

  logic [P-1:0][WEIGHTw-1:0]   pcnt_r, pcnt_s;
  logic [P-1:0][WEIGHTw-1:0]   wa_r, wa_s;
  logic [P*V-1:0][WEIGHTw-1:0] vcnt_r, vcnt_s;
  logic [P-1:0]                ic_r, ic_s;
  logic [P*V-1:0]              vc_r, vc_s;
`ifdef SWA_WEIGHT_IDLE_RESET_EN
  localparam logic [WEIGHTw-1:0] IDLE_MAX = {WEIGHTw{1'b1}};
  logic [P-1:0][WEIGHTw-1:0]   idle_r, idle_s;
`endif

  // Next-state counters, shadow weight and decoded outputs.
  always_comb begin
    pcnt_s = pcnt_r;
    wa_s   = wa_r;
    vcnt_s = vcnt_r;
    ic_s   = '0;
    vc_s   = '0;
`ifdef SWA_WEIGHT_IDLE_RESET_EN
    idle_s = idle_r;
`endif
    for (int p = 0; p < P; p++) begin
      if (any_ivc_sw_request_granted_all[p]) begin
        if (pcnt_r[p] == quota_last(wa_r[p])) begin
          pcnt_s[p] = CNT_ZERO;
        end else begin
          pcnt_s[p] = pcnt_r[p] + CNT_ONE;
        end
      end else begin
        pcnt_s[p] = pcnt_r[p];
      end
`ifdef SWA_WEIGHT_IDLE_RESET_EN
      // A long-idle port forgets its partial quota so returning traffic starts fresh.
      if (|ivc_request_all[p*V +: V]) begin
        idle_s[p] = CNT_ZERO;
      end else if (idle_r[p] == IDLE_MAX) begin
        idle_s[p] = CNT_ZERO;
        pcnt_s[p] = CNT_ZERO;
      end else begin
        idle_s[p] = idle_r[p] + CNT_ONE;
      end
`endif
      // Reloading only at a quota boundary keeps a weight change from splitting a quota.
      if (pcnt_s[p] == CNT_ZERO) begin
        wa_s[p] = iport_weight_all[p*WEIGHTw +: WEIGHTw];
      end else begin
        wa_s[p] = wa_r[p];
      end
      ic_s[p] = (pcnt_s[p] == quota_last(wa_s[p]));

      for (int v = 0; v < V; v++) begin
        if (ivc_num_getting_sw_grant[p*V+v]) begin
          if (vcnt_r[p*V+v] == VC_LAST) begin
            vcnt_s[p*V+v] = CNT_ZERO;
          end else begin
            vcnt_s[p*V+v] = vcnt_r[p*V+v] + CNT_ONE;
          end
        end else if ((|ivc_num_getting_sw_grant[p*V +: V]) || !ivc_request_all[p*V+v]) begin
          vcnt_s[p*V+v] = CNT_ZERO;
        end else begin
          vcnt_s[p*V+v] = vcnt_r[p*V+v];
        end
        vc_s[p*V+v] = (vcnt_s[p*V+v] == VC_LAST);
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      pcnt_r <= '0;
      wa_r   <= {P{CNT_ONE}};
      vcnt_r <= '0;
      ic_r   <= '0;
      vc_r   <= '0;
`ifdef SWA_WEIGHT_IDLE_RESET_EN
      idle_r <= '0;
`endif
    end else begin
      pcnt_r <= pcnt_s;
      wa_r   <= wa_s;
      vcnt_r <= vcnt_s;
      ic_r   <= ic_s;
      vc_r   <= vc_s;
`ifdef SWA_WEIGHT_IDLE_RESET_EN
      idle_r <= idle_s;
`endif
    end
  end

  assign iport_weight_is_consumed_all = ic_r;
  assign vc_weight_is_consumed_all    = vc_r;
  assign weight_active_all            = wa_r;

  swa_weight_ctrl_chk #(.P(P), .V(V)) u_chk (
    .clk   (clk),
    .reset (reset),
    .grant (ivc_num_getting_sw_grant)
  );

endmodule

// Flags more than one switch grant within a single port.
module swa_weight_ctrl_chk #(
  parameter int P = 5,
  parameter int V = 4
) (
  input logic           clk,
  input logic           reset,
  input logic [P*V-1:0] grant
);
  for (genvar p = 0; p < P; p++) begin : g_port
    a_grant_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(grant[p*V +: V]));
  end
endmodule

// File: tb/tb_swa_weight_ctrl.sv
// Table-driven scoreboard bench for swa_weight_ctrl (P=5, V=4, WEIGHTw=4, VC_WEIGHT=2).
module tb_swa_weight_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [19:0] weight;
  logic [19:0] req;
  logic [19:0] gnt;
  logic [4:0]  gnt_any;
  logic [4:0]  ic;
  logic [19:0] vc;
  logic [19:0] wa;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        rst;
    logic [19:0] w;
    logic [19:0] rq;
    logic [19:0] g;
    logic [4:0]  e_ic;
    logic [19:0] e_vc;
    logic [19:0] e_wa;
  } vec_t;

  typedef struct {
    logic [4:0]  ic;
    logic [19:0] vc;
    logic [19:0] wa;
    string       tag;
  } exp_t;

  vec_t tbl[39];
  exp_t sb[$];

  swa_weight_ctrl dut (
    .clk                            (clk),
    .reset                          (reset),
    .iport_weight_all               (weight),
    .ivc_request_all                (req),
    .ivc_num_getting_sw_grant       (gnt),
    .any_ivc_sw_request_granted_all (gnt_any),
    .iport_weight_is_consumed_all   (ic),
    .vc_weight_is_consumed_all      (vc),
    .weight_active_all              (wa)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [19:0] act, input logic [19:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic apply(input logic r, input logic [19:0] w, input logic [19:0] rq,
                       input logic [19:0] g, input logic [4:0] e_ic, input logic [19:0] e_vc,
                       input logic [19:0] e_wa, input string tag);
    exp_t e;
    reset  = r;
    weight = w;
    req    = rq;
    gnt    = g;
    for (int p = 0; p < 5; p++) gnt_any[p] = |g[p*4 +: 4];
    sb.push_back('{e_ic, e_vc, e_wa, tag});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check({e.tag, " consumed"}, {15'd0, ic}, {15'd0, e.ic});
    check({e.tag, " vc"}, vc, e.vc);
    check({e.tag, " weight"}, wa, e.wa);
  endtask

`ifdef SWA_WEIGHT_IDLE_RESET_EN
  localparam logic [19:0] IDLE_WA  = 20'h41123;
  localparam logic [4:0]  AFTER_IC = 5'h0C;
`else
  localparam logic [19:0] IDLE_WA  = 20'h51123;
  localparam logic [4:0]  AFTER_IC = 5'h1C;
`endif

  initial begin
    // reset state
    tbl[0]  = '{1'b1, 20'h11111, 20'h00000, 20'h00000, 5'h00, 20'h00000, 20'h11111};
    tbl[1]  = '{1'b1, 20'h11111, 20'h00000, 20'h00000, 5'h00, 20'h00000, 20'h11111};
    tbl[2]  = '{1'b0, 20'h11111, 20'h00000, 20'h00000, 5'h1F, 20'h00000, 20'h11111};
    // port 0 weight 3
    tbl[3]  = '{1'b0, 20'h11113, 20'h00001, 20'h00001, 5'h1E, 20'h00001, 20'h11113};
    tbl[4]  = '{1'b0, 20'h11113, 20'h00001, 20'h00001, 5'h1E, 20'h00000, 20'h11113};
    tbl[5]  = '{1'b0, 20'h11113, 20'h00001, 20'h00001, 5'h1F, 20'h00001, 20'h11113};
    tbl[6]  = '{1'b0, 20'h11113, 20'h00001, 20'h00001, 5'h1E, 20'h00000, 20'h11113};
    tbl[7]  = '{1'b0, 20'h11113, 20'h00000, 20'h00000, 5'h1E, 20'h00000, 20'h11113};
    // port 2 weight 0
    tbl[8]  = '{1'b0, 20'h11013, 20'h00100, 20'h00100, 5'h1E, 20'h00100, 20'h11013};
    tbl[9]  = '{1'b0, 20'h11013, 20'h00100, 20'h00100, 5'h1E, 20'h00000, 20'h11013};
    tbl[10] = '{1'b0, 20'h11013, 20'h00100, 20'h00100, 5'h1E, 20'h00100, 20'h11013};
    tbl[11] = '{1'b0, 20'h11013, 20'h00000, 20'h00000, 5'h1E, 20'h00000, 20'h11013};
    // port 1 weight 4 -> 2 mid-quota
    tbl[12] = '{1'b0, 20'h11143, 20'h00000, 20'h00000, 5'h1C, 20'h00000, 20'h11143};
    tbl[13] = '{1'b0, 20'h11143, 20'h00010, 20'h00010, 5'h1C, 20'h00010, 20'h11143};
    tbl[14] = '{1'b0, 20'h11143, 20'h00010, 20'h00010, 5'h1C, 20'h00000, 20'h11143};
    tbl[15] = '{1'b0, 20'h11123, 20'h00010, 20'h00010, 5'h1E, 20'h00010, 20'h11143};
    tbl[16] = '{1'b0, 20'h11123, 20'h00010, 20'h00010, 5'h1C, 20'h00000, 20'h11123};
    tbl[17] = '{1'b0, 20'h11123, 20'h00010, 20'h00010, 5'h1E, 20'h00010, 20'h11123};
    // port 3 VC switching and request drops
    tbl[18] = '{1'b0, 20'h11123, 20'h06000, 20'h02000, 5'h1E, 20'h02000, 20'h11123};
    tbl[19] = '{1'b0, 20'h11123, 20'h06000, 20'h04000, 5'h1E, 20'h04000, 20'h11123};
    tbl[20] = '{1'b0, 20'h11123, 20'h06000, 20'h02000, 5'h1E, 20'h02000, 20'h11123};
    tbl[21] = '{1'b0, 20'h11123, 20'h04000, 20'h00000, 5'h1E, 20'h00000, 20'h11123};
    tbl[22] = '{1'b0, 20'h11123, 20'h06000, 20'h04000, 5'h1E, 20'h04000, 20'h11123};
    tbl[23] = '{1'b0, 20'h11123, 20'h02000, 20'h00000, 5'h1E, 20'h00000, 20'h11123};
    tbl[24] = '{1'b0, 20'h11123, 20'h04000, 20'h04000, 5'h1E, 20'h04000, 20'h11123};
    tbl[25] = '{1'b0, 20'h11123, 20'h04000, 20'h00000, 5'h1E, 20'h04000, 20'h11123};
    tbl[26] = '{1'b0, 20'h11123, 20'h04000, 20'h04000, 5'h1E, 20'h00000, 20'h11123};
    // port 4 weight 5, reset mid-quota, restart from 0
    tbl[27] = '{1'b0, 20'h51123, 20'h00000, 20'h00000, 5'h0E, 20'h00000, 20'h51123};
    tbl[28] = '{1'b0, 20'h51123, 20'h10000, 20'h10000, 5'h0E, 20'h10000, 20'h51123};
    tbl[29] = '{1'b0, 20'h51123, 20'h10000, 20'h10000, 5'h0E, 20'h00000, 20'h51123};
    tbl[30] = '{1'b1, 20'h51123, 20'h10000, 20'h10000, 5'h00, 20'h00000, 20'h11111};
    tbl[31] = '{1'b0, 20'h51123, 20'h10000, 20'h10000, 5'h0C, 20'h10000, 20'h51123};
    tbl[32] = '{1'b0, 20'h51123, 20'h10000, 20'h10000, 5'h0C, 20'h00000, 20'h51123};
    tbl[33] = '{1'b0, 20'h51123, 20'h10000, 20'h10000, 5'h0C, 20'h10000, 20'h51123};
    tbl[34] = '{1'b0, 20'h51123, 20'h10000, 20'h10000, 5'h0C, 20'h00000, 20'h51123};
    tbl[35] = '{1'b0, 20'h51123, 20'h10000, 20'h10000, 5'h1C, 20'h10000, 20'h51123};
    tbl[36] = '{1'b0, 20'h51123, 20'h10000, 20'h10000, 5'h0C, 20'h00000, 20'h51123};
    // bring port 4 to pcnt = 2 ahead of the idle period
    tbl[37] = '{1'b0, 20'h51123, 20'h10000, 20'h10000, 5'h0C, 20'h10000, 20'h51123};
    tbl[38] = '{1'b0, 20'h51123, 20'h10000, 20'h10000, 5'h0C, 20'h00000, 20'h51123};

    reset = 1'b1; weight = '0; req = '0; gnt = '0; gnt_any = '0;

    for (int i = 0; i < 39; i++) begin
      apply(tbl[i].rst, tbl[i].w, tbl[i].rq, tbl[i].g, tbl[i].e_ic, tbl[i].e_vc, tbl[i].e_wa,
            $sformatf("vec%0d", i));
    end

    // idle period: 16 cycles with no requests while the port 4 weight input changes to 4
    for (int k = 1; k <= 16; k++) begin
      apply(1'b0, 20'h41123, 20'h00000, 20'h00000, 5'h0C, 20'h00000,
            (k == 16) ? IDLE_WA : 20'h51123, $sformatf("idle%0d", k));
    end

    // returning traffic: a fresh quota of 4, or the stale count continuing toward 5
    apply(1'b0, 20'h41123, 20'h10000, 20'h10000, 5'h0C, 20'h10000, IDLE_WA, "after_idle1");
    apply(1'b0, 20'h41123, 20'h10000, 20'h10000, AFTER_IC, 20'h00000, IDLE_WA, "after_idle2");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
